// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch sequencer.
// Optional build macro PC_ALIGN_CHK_EN is consumed by pc_fetch_ctrl.
package pc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int PC_INC  = 2;

  localparam logic [ADDR_W-1:0] RESET_VEC  = 16'h0000;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_INC - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALTED
  } state_e;

  typedef enum logic {
    SEL_INC,
    SEL_REDIR
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: imem request/ack, decode handshake, redirect and halt.
// master = sequencer side, slave = memory/decode/branch side.
interface pc_fetch_ctrl_if;
  import pc_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               halt_req;
  logic               halted;
  logic               misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  id_ready,
    input  redirect_valid, redirect_target,
    input  halt_req,
    output halted, misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output id_ready,
    output redirect_valid, redirect_target,
    output halt_req,
    input  halted, misalign_err
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: async reset, load enable,
// next value is either pc+PC_INC (wrapping) or a redirect target.
module pc_reg
  import pc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] redir_tgt,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc + ADDR_W'(PC_INC);
    if (sel == SEL_REDIR) pc_nxt = redir_tgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_VEC;
    end else if (ld_en) begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Handshaked fetch sequencer: owns the PC, issues imem requests, holds for decode.
// Define PC_ALIGN_CHK_EN to reject misaligned redirects and flag misalign_err.
module pc_fetch_ctrl
  import pc_pkg::*;
(
  input logic             clk,
  input logic             rst,
  pc_fetch_ctrl_if.master bus
);

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tgt;
  logic              redir;
  logic              squash;
  logic              halt_pend;
  logic              halt_now;
  logic              pc_ld;
  pc_sel_e           pc_sel;

  assign tgt      = bus.redirect_target & ~ALIGN_MASK;
  assign halt_now = halt_pend | bus.halt_req;

`ifdef PC_ALIGN_CHK_EN
  logic bad;
  logic mis_q;

  assign bad   = |(bus.redirect_target & ALIGN_MASK);
  assign redir = bus.redirect_valid & ~bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (bus.redirect_valid && bad) begin
      mis_q <= 1'b1;
    end
  end

  assign bus.misalign_err = mis_q;
`else
  assign redir            = bus.redirect_valid;
  assign bus.misalign_err = 1'b0;
`endif

  always_comb begin
    pc_ld  = 1'b0;
    pc_sel = SEL_INC;
    if (redir) begin
      pc_ld  = 1'b1;
      pc_sel = SEL_REDIR;
    end else if (state == REQ && bus.imem_ack && !squash) begin
      pc_ld = 1'b1;
    end
  end

  pc_reg u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (pc_ld),
    .sel       (pc_sel),
    .redir_tgt (tgt),
    .pc        (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_VEC;
      bus.if_valid  <= 1'b0;
      bus.if_instr  <= '0;
      bus.if_pc     <= '0;
      bus.halted    <= 1'b0;
      squash        <= 1'b0;
      halt_pend     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redir) begin
            state         <= REQ;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= tgt;
            halt_pend     <= halt_now;
          end else if (halt_now) begin
            state      <= HALTED;
            bus.halted <= 1'b1;
            halt_pend  <= 1'b0;
          end else begin
            state         <= REQ;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
          end
        end
        REQ: begin
          if (bus.halt_req) halt_pend <= 1'b1;
          if (bus.imem_ack) begin
            // Stale or redirected data: reissue at the live pc.
            if (squash || redir) begin
              squash        <= 1'b0;
              bus.imem_addr <= redir ? tgt : pc;
            end else begin
              state        <= HOLD;
              bus.imem_req <= 1'b0;
              bus.if_valid <= 1'b1;
              bus.if_instr <= bus.imem_rdata;
              bus.if_pc    <= bus.imem_addr;
            end
          end else if (redir) begin
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.halt_req) halt_pend <= 1'b1;
          if (redir) begin
            state         <= REQ;
            bus.if_valid  <= 1'b0;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= tgt;
          end else if (bus.id_ready) begin
            bus.if_valid <= 1'b0;
            if (halt_now) begin
              state      <= HALTED;
              bus.halted <= 1'b1;
              halt_pend  <= 1'b0;
            end else begin
              state         <= REQ;
              bus.imem_req  <= 1'b1;
              bus.imem_addr <= pc;
            end
          end
        end
        HALTED: begin
          if (redir) begin
            state         <= REQ;
            bus.halted    <= 1'b0;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= tgt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; expectations follow PC_ALIGN_CHK_EN.
module tb_pc_fetch_ctrl;
  import pc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] d);
    chk("req_hi", 32'(bus.imem_req), 32'd1);
    chk("req_addr", 32'(bus.imem_addr), 32'(a));
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    chk("hold_valid", 32'(bus.if_valid), 32'd1);
    chk("hold_instr", 32'(bus.if_instr), 32'(d));
    chk("hold_pc", 32'(bus.if_pc), 32'(a));
    chk("hold_req_lo", 32'(bus.imem_req), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = 16'h0000;
    bus.id_ready        = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 16'h0000;
    bus.halt_req        = 1'b0;
    step();
    step();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_instr", 32'(bus.if_instr), 32'd0);
    chk("rst_mis", 32'(bus.misalign_err), 32'd0);

    // Sequential fetch: 0, 2, 4 at one per 2 cycles
    rst = 1'b0;
    step();
    fetch(16'h0000, 16'hA000);
    step();
    bus.id_ready = 1'b0;
    fetch(16'h0002, 16'hA002);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(bus.if_valid), 32'd1);
      chk("bp_instr", 32'(bus.if_instr), 32'h0000A002);
      chk("bp_req", 32'(bus.imem_req), 32'd0);
    end
    bus.id_ready = 1'b1;
    step();
    fetch(16'h0004, 16'hA004);
    step();

    // Redirect while request to 6 is outstanding
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0100;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd_addr_hold", 32'(bus.imem_addr), 32'h6);
    chk("rd_req_hold", 32'(bus.imem_req), 32'd1);
    step();
    chk("rd_addr_hold2", 32'(bus.imem_addr), 32'h6);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    step();
    bus.imem_ack = 1'b0;
    chk("sq_valid", 32'(bus.if_valid), 32'd0);
    chk("sq_addr", 32'(bus.imem_addr), 32'h100);

    // Redirect coincident with ack
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0040;
    bus.imem_ack        = 1'b1;
    bus.imem_rdata      = 16'hBEEF;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_ack       = 1'b0;
    chk("co_valid", 32'(bus.if_valid), 32'd0);
    chk("co_addr", 32'(bus.imem_addr), 32'h40);
    fetch(16'h0040, 16'h1111);

    // Redirect with accept in HOLD drops the held instruction
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0080;
    step();
    bus.redirect_valid = 1'b0;
    chk("rh_valid", 32'(bus.if_valid), 32'd0);
    chk("rh_req", 32'(bus.imem_req), 32'd1);
    chk("rh_addr", 32'(bus.imem_addr), 32'h80);

    // Halt after the next accepted instruction
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    chk("hp_halted", 32'(bus.halted), 32'd0);
    fetch(16'h0080, 16'h2222);
    step();
    chk("h_halted", 32'(bus.halted), 32'd1);
    chk("h_req", 32'(bus.imem_req), 32'd0);
    step();
    chk("h_req2", 32'(bus.imem_req), 32'd0);

    // Resume at 0xFFFE and check wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'hFFFE;
    step();
    bus.redirect_valid = 1'b0;
    chk("res_halted", 32'(bus.halted), 32'd0);
    fetch(16'hFFFE, 16'h3333);
    step();
    chk("wrap_addr", 32'(bus.imem_addr), 32'h0);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    fetch(16'h0000, 16'h4444);
    step();
    chk("h2_halted", 32'(bus.halted), 32'd1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0010;
    step();
    bus.redirect_valid = 1'b0;
    chk("r10_req", 32'(bus.imem_req), 32'd1);
    chk("r10_addr", 32'(bus.imem_addr), 32'h10);

    // Asynchronous reset mid-REQ, redirect ignored while in reset
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(bus.imem_req), 32'd0);
    chk("ar_instr", 32'(bus.if_instr), 32'd0);
    chk("ar_halted", 32'(bus.halted), 32'd0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0200;
    step();
    chk("ar_req2", 32'(bus.imem_req), 32'd0);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    chk("rel_req", 32'(bus.imem_req), 32'd1);
    chk("rel_addr", 32'(bus.imem_addr), 32'(RESET_VEC));

    // Odd redirect target
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0013;
    step();
    bus.redirect_valid = 1'b0;
    chk("odd_addr", 32'(bus.imem_addr), 32'h0);
`ifdef PC_ALIGN_CHK_EN
    chk("odd_mis", 32'(bus.misalign_err), 32'd1);
`else
    chk("odd_mis", 32'(bus.misalign_err), 32'd0);
`endif
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h6666;
    step();
    bus.imem_ack = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    chk("odd_valid", 32'(bus.if_valid), 32'd1);
    chk("odd_pc", 32'(bus.if_pc), 32'h0);
    chk("odd_mis_sticky", 32'(bus.misalign_err), 32'd1);
`else
    chk("odd_valid", 32'(bus.if_valid), 32'd0);
    chk("odd_addr2", 32'(bus.imem_addr), 32'h12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
